// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/busy/done handshake.
// Single-cycle ops complete in one cycle. mul, divu and remu run on an
// iterative engine that handles one operand bit per cycle.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             dz,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIVU = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SLTU = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_SLL  = 4'hA;
  localparam logic [3:0] OP_SRL  = 4'hB;
  localparam logic [3:0] OP_SRA  = 4'hC;
  localparam logic [3:0] OP_REMU = 4'hD;

  // The counter must hold the value WIDTH itself.
  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] val;
    logic             carry;
    logic             ovf;
    logic             dz;
    logic             err;
  } result_t;

  state_t state, state_nxt;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc, x_q, y_q;
  logic [WIDTH-1:0] acc_nxt, x_nxt, y_nxt;
  logic [CW-1:0]    cnt;

  logic             accept, is_iter, go_run, last_step;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   div_shift, div_trial;
  result_t          sc_r, it_r, wr_r;
  logic             wr_en;

  // start is only looked at in IDLE; DONE drops it so the next accept
  // comes one cycle after done at the earliest.
  assign accept    = (state == S_IDLE) && start;
  assign is_iter   = (sel == OP_MUL) || (sel == OP_DIVU) || (sel == OP_REMU);
  // Divide by zero (and mul by zero, whose product is simply 0) skip the
  // engine and finish in one cycle.
  assign go_run    = accept && is_iter && (|B);
  assign last_step = (state == S_RUN) && (cnt == CW'(1));
  assign shamt     = B[SHW-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = go_run ? S_RUN : S_DONE;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Single-cycle results, evaluated straight from the inputs on the accept edge.
  always_comb begin
    sum  = {1'b0, A} + {1'b0, B};
    diff = A - B;
    sc_r = '0;
    unique case (sel)
      OP_ADD: begin
        sc_r.val   = sum[WIDTH-1:0];
        sc_r.carry = sum[WIDTH];
        sc_r.ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_r.val   = diff;
        sc_r.carry = (A < B);
        sc_r.ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL:  sc_r.val = '0;
      OP_DIVU: begin
        sc_r.val = '1;
        sc_r.dz  = 1'b1;
      end
      OP_REMU: begin
        sc_r.val = A;
        sc_r.dz  = 1'b1;
      end
      OP_AND:  sc_r.val = A & B;
      OP_OR:   sc_r.val = A | B;
      OP_XOR:  sc_r.val = A ^ B;
      OP_NOT:  sc_r.val = ~A;
      OP_SLTU: sc_r.val = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLT:  sc_r.val = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL:  sc_r.val = A << shamt;
      OP_SRL:  sc_r.val = A >> shamt;
      OP_SRA:  sc_r.val = $unsigned($signed(A) >>> shamt);
      default: sc_r.err = 1'b1;
    endcase
  end

  // One engine step: shift-add multiply, or one restoring-division bit.
  // For mul: acc = partial product, x = shifted multiplicand, y = multiplier.
  // For div: acc = partial remainder, x = dividend shifting into quotient,
  // y = divisor.
  always_comb begin
    acc_nxt   = acc;
    x_nxt     = x_q;
    y_nxt     = y_q;
    div_shift = {acc, x_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, y_q};
    if (op_q == OP_MUL) begin
      acc_nxt = y_q[0] ? (acc + x_q) : acc;
      x_nxt   = x_q << 1;
      y_nxt   = y_q >> 1;
    end else begin
      // A non-negative trial keeps the subtraction and sets the quotient bit.
      acc_nxt = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      x_nxt   = {x_q[WIDTH-2:0], ~div_trial[WIDTH]};
    end
    it_r     = '0;
    it_r.val = (op_q == OP_DIVU) ? x_nxt : acc_nxt;
  end

  // Choose what gets registered and when.
  always_comb begin
    wr_en = (accept && !go_run) || last_step;
    wr_r  = last_step ? it_r : sc_r;
  end

  // Operand latch and iterative engine state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      acc  <= '0;
      x_q  <= '0;
      y_q  <= '0;
      cnt  <= '0;
    end else if (accept) begin
      op_q <= sel;
      acc  <= '0;
      x_q  <= A;
      y_q  <= B;
      cnt  <= go_run ? CW'(WIDTH) : '0;
    end else if (state == S_RUN) begin
      acc  <= acc_nxt;
      x_q  <= x_nxt;
      y_q  <= y_nxt;
      cnt  <= cnt - CW'(1);
    end
  end

  // Result and flags; they change only when a result is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res   <= '0;
      zero  <= 1'b1;
      neg   <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      dz    <= 1'b0;
      err   <= 1'b0;
    end else if (wr_en) begin
      res   <= wr_r.val;
      zero  <= (wr_r.val == '0);
      neg   <= wr_r.val[WIDTH-1];
      carry <= wr_r.carry;
      ovf   <= wr_r.ovf;
      dz    <= wr_r.dz;
      err   <= wr_r.err;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq at WIDTH=32 and WIDTH=8
// against an arithmetic reference model.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        st32, st8;
  logic [31:0] a32, b32, r32;
  logic [7:0]  a8, b8, r8;
  logic [3:0]  sel32, sel8;
  logic        z32, n32, c32, o32, d32, e32, bz32, dn32;
  logic        z8, n8, c8, o8, d8, e8, bz8, dn8;

  int tests = 0;
  int fails = 0;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .A(a32), .B(b32), .sel(sel32),
    .res(r32), .zero(z32), .neg(n32), .carry(c32), .ovf(o32), .dz(d32),
    .err(e32), .busy(bz32), .done(dn32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .A(a8), .B(b8), .sel(sel8),
    .res(r8), .zero(z8), .neg(n8), .carry(c8), .ovf(o8), .dz(d8),
    .err(e8), .busy(bz8), .done(dn8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_res(input int w);
    return (w == 32) ? r32 : {24'h0, r8};
  endfunction

  // {zero, neg, carry, ovf, dz, err}
  function automatic logic [5:0] obs_flags(input int w);
    return (w == 32) ? {z32, n32, c32, o32, d32, e32} : {z8, n8, c8, o8, d8, e8};
  endfunction

  function automatic logic obs_busy(input int w);
    return (w == 32) ? bz32 : bz8;
  endfunction

  function automatic logic obs_done(input int w);
    return (w == 32) ? dn32 : dn8;
  endfunction

  task automatic drive(input int w, input logic st, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      st32 = st; sel32 = s; a32 = a; b32 = b;
    end else begin
      st8 = st; sel8 = s; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  function automatic longint sx(input longint unsigned v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Reference model: plain integer arithmetic on w-bit values.
  task automatic model(input int w, input logic [3:0] s, input longint unsigned a,
                       input longint unsigned b, output longint unsigned r,
                       output logic [5:0] f, output int lat);
    longint unsigned m   = (longint'(1) << w) - 1;
    longint          lim = longint'(1) << (w - 1);
    longint          sa  = sx(a, w);
    longint          sb  = sx(b, w);
    longint          t;
    int              sh  = int'(b % longint'(w));
    logic cy = 1'b0, ov = 1'b0, dzf = 1'b0, er = 1'b0;
    lat = 1;
    r   = 0;
    case (s)
      4'h0: begin r = (a + b) & m; cy = ((a + b) >> w) != 0; t = sa + sb; ov = (t >= lim) || (t < -lim); end
      4'h1: begin r = (a - b) & m; cy = (a < b); t = sa - sb; ov = (t >= lim) || (t < -lim); end
      4'h2: begin r = (a * b) & m; if (b != 0) lat = w + 1; end
      4'h3: begin if (b == 0) begin r = m; dzf = 1'b1; end else begin r = a / b; lat = w + 1; end end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a & m;
      4'h8: r = (a < b) ? 1 : 0;
      4'h9: r = (sa < sb) ? 1 : 0;
      4'hA: r = (a << sh) & m;
      4'hB: r = a >> sh;
      4'hC: r = longint'(sa >>> sh) & m;
      4'hD: begin if (b == 0) begin r = a; dzf = 1'b1; end else begin r = a % b; lat = w + 1; end end
      default: er = 1'b1;
    endcase
    f = {(r == 0), r[w-1], cy, ov, dzf, er};
  endtask

  // Issue one request, wait for done, check result, flags, latency and busy
  // time, then check that done drops and the result holds.
  task automatic do_op(input int w, input logic [3:0] s, input logic [31:0] ai,
                       input logic [31:0] bi, input bit toggle, output logic [31:0] got);
    longint unsigned m = (longint'(1) << w) - 1;
    longint unsigned a = longint'(ai) & m;
    longint unsigned b = longint'(bi) & m;
    longint unsigned er;
    logic [5:0]      ef;
    int              lat, n, nb;
    string           tg;
    model(w, s, a, b, er, ef, lat);
    tg = $sformatf("w%0d op%0h a=%0h b=%0h", w, s, a, b);
    @(negedge clk);
    drive(w, 1'b1, s, 32'(a), 32'(b));
    @(posedge clk);
    #1 drive(w, 1'b0, s, 32'(a), 32'(b));
    n  = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (obs_busy(w)) nb++;
      if (toggle && !obs_done(w)) drive(w, 1'b0, 4'($urandom), $urandom, $urandom);
    end while (!obs_done(w) && n < 100);
    chk({tg, " latency"}, 32'(n), 32'(lat));
    chk({tg, " busy cycles"}, 32'(nb), (lat > 1) ? 32'(w) : 32'd0);
    chk({tg, " res"}, obs_res(w), 32'(er));
    chk({tg, " flags"}, 32'(obs_flags(w)), 32'(ef));
    got = obs_res(w);
    @(negedge clk);
    chk({tg, " done pulse width"}, 32'(obs_done(w)), 32'd0);
    chk({tg, " res hold"}, obs_res(w), 32'(er));
  endtask

  initial begin
    logic [31:0] got, ra, rb;
    logic [3:0]  rs;
    int          dcnt, w;
    logic        pd;

    rst_n = 1'b0;
    drive(32, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(8, 1'b0, 4'h0, 32'h0, 32'h0);
    #12;
    chk("reset res32", r32, 32'h0);
    chk("reset flags32", 32'(obs_flags(32)), 32'b100000);
    chk("reset busy/done32", {30'h0, bz32, dn32}, 32'h0);
    chk("reset flags8", 32'(obs_flags(8)), 32'b100000);
    @(negedge clk);
    rst_n = 1'b1;

    // add / sub at WIDTH=32
    do_op(32, 4'h0, 32'h7FFF_FFFF, 32'h1, 1'b0, got);
    chk("add32 literal", got, 32'h8000_0000);
    do_op(32, 4'h1, 32'd3, 32'd5, 1'b0, got);
    chk("sub32 literal", got, 32'hFFFF_FFFE);

    // Reset in the middle of a mul aborts it with no done.
    @(negedge clk);
    drive(32, 1'b1, 4'h2, 32'd7, 32'd9);
    @(posedge clk);
    #1 drive(32, 1'b0, 4'h2, 32'd7, 32'd9);
    repeat (4) @(posedge clk);
    #2 chk("mul busy before reset", 32'(bz32), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset res", r32, 32'h0);
    chk("midreset flags", 32'(obs_flags(32)), 32'b100000);
    chk("midreset busy/done", {30'h0, bz32, dn32}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (dn32) dcnt++;
    end
    chk("no done after abort", 32'(dcnt), 32'd0);

    // iterative ops at WIDTH=32; operands toggle during RUN for mul
    do_op(32, 4'h2, 32'h0001_0000, 32'h0001_0003, 1'b1, got);
    chk("mul32 literal", got, 32'h0003_0000);
    do_op(32, 4'h3, 32'd100, 32'd7, 1'b1, got);
    chk("divu32 literal", got, 32'd14);
    do_op(32, 4'hD, 32'd100, 32'd7, 1'b0, got);
    chk("remu32 literal", got, 32'd2);
    do_op(32, 4'h3, 32'd5, 32'd0, 1'b0, got);
    chk("divu32 by zero literal", got, 32'hFFFF_FFFF);
    do_op(32, 4'hD, 32'd5, 32'd0, 1'b0, got);
    chk("remu32 by zero literal", got, 32'd5);

    // compares and arithmetic shift
    do_op(32, 4'h9, 32'hFFFF_FFFF, 32'd1, 1'b0, got);
    chk("slt32 literal", got, 32'd1);
    do_op(32, 4'h8, 32'hFFFF_FFFF, 32'd1, 1'b0, got);
    chk("sltu32 literal", got, 32'd0);
    do_op(32, 4'hC, 32'h8000_0000, 32'h0000_0024, 1'b0, got);
    chk("sra32 literal", got, 32'hF800_0000);

    // start held high with an invalid opcode: done every other cycle
    @(negedge clk);
    drive(32, 1'b1, 4'hE, $urandom, $urandom);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dn32) dcnt++;
      chk($sformatf("held start done pattern %0d", i), 32'(dn32), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (dn32) begin
        chk("invalid res", r32, 32'h0);
        chk("invalid flags", 32'(obs_flags(32)), 32'b100001);
      end
    end
    st32 = 1'b0;
    chk("held start done count", 32'(dcnt), 32'd6);

    // WIDTH=8 repeats
    do_op(8, 4'h0, 32'h7F, 32'h1, 1'b0, got);
    chk("add8 literal", got, 32'h80);
    do_op(8, 4'h1, 32'd3, 32'd5, 1'b0, got);
    chk("sub8 literal", got, 32'hFE);
    do_op(8, 4'h2, 32'h10, 32'h13, 1'b1, got);
    chk("mul8 literal", got, 32'h30);
    do_op(8, 4'h3, 32'd100, 32'd7, 1'b1, got);
    chk("divu8 literal", got, 32'd14);
    do_op(8, 4'h3, 32'd5, 32'd0, 1'b0, got);
    chk("divu8 by zero literal", got, 32'hFF);

    // random mix on both widths
    for (int i = 0; i < 60; i++) begin
      w  = (i % 2 == 0) ? 32 : 8;
      rs = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ((rs == 4'h3 || rs == 4'hD) && ($urandom_range(0, 5) == 0)) rb = 32'h0;
      if (rs == 4'h2 && ((w == 8 && rb[7:0] == 8'h0) || rb == 32'h0)) rb = 32'h1;
      pd = 1'($urandom_range(0, 1));
      do_op(w, rs, ra, rb, pd, got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
